// File: rtl/s10000001_frame_tx.sv
// s10000001_frame_tx
//   Serial frame source for the 10000001 sequence detector. A word captured on
//   start is shifted out MSB-first on the registered line J, one bit per clock,
//   optionally followed by an idle gap of 'gap' cycles.
//   Build option: define PREAMBLE_EN to prefix every payload with the SYNC word.
module s10000001_frame_tx #(
    parameter int unsigned       WIDTH = 8,
    parameter int unsigned       GAP_W = 4,
    parameter logic [WIDTH-1:0]  SYNC  = 8'b10000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [GAP_W-1:0] gap,
    output logic             J,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   shift, shift_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [GAP_W-1:0]   gcnt, gcnt_n;
    logic               j_n;
    logic               ready_n;
    logic               done_n;

`ifdef PREAMBLE_EN
    logic [WIDTH-1:0]   pre_sh, pre_sh_n;
`else
    // SYNC only matters when the preamble is built in.
    logic               unused_sync;
    assign unused_sync = ^SYNC;
`endif

    // Next-state and next-output logic; J carries the bit for the coming cycle.
    always_comb begin
        state_n  = state;
        shift_n  = shift;
        cnt_n    = cnt;
        gcnt_n   = gcnt;
        j_n      = 1'b0;
        done_n   = 1'b0;
`ifdef PREAMBLE_EN
        pre_sh_n = pre_sh;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    gcnt_n = gap;
                    cnt_n  = CNT_W'(WIDTH - 1);
`ifdef PREAMBLE_EN
                    state_n  = PRE;
                    j_n      = SYNC[WIDTH-1];
                    pre_sh_n = SYNC << 1;
                    shift_n  = data;
`else
                    state_n  = SEND;
                    j_n      = data[WIDTH-1];
                    shift_n  = data << 1;
`endif
                end
            end

            PRE: begin
`ifdef PREAMBLE_EN
                if (cnt != '0) begin
                    j_n      = pre_sh[WIDTH-1];
                    pre_sh_n = pre_sh << 1;
                    cnt_n    = cnt - 1'b1;
                end else begin
                    // Last SYNC bit has been shown; first payload bit follows directly.
                    state_n = SEND;
                    j_n     = shift[WIDTH-1];
                    shift_n = shift << 1;
                    cnt_n   = CNT_W'(WIDTH - 1);
                end
`else
                state_n = IDLE;
`endif
            end

            SEND: begin
                // cnt is the index of the payload bit currently on J.
                if (cnt != '0) begin
                    j_n     = shift[WIDTH-1];
                    shift_n = shift << 1;
                    cnt_n   = cnt - 1'b1;
                end else begin
                    done_n  = 1'b1;
                    state_n = (gcnt != '0) ? GAP : IDLE;
                end
            end

            GAP: begin
                gcnt_n = gcnt - 1'b1;
                if (gcnt <= GAP_W'(1)) begin
                    state_n = IDLE;
                    gcnt_n  = '0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
        ready_n = (state_n == IDLE);
    end

    // State, datapath and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shift  <= '0;
            cnt    <= '0;
            gcnt   <= '0;
            J      <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef PREAMBLE_EN
            pre_sh <= '0;
`endif
        end else begin
            state  <= state_n;
            shift  <= shift_n;
            cnt    <= cnt_n;
            gcnt   <= gcnt_n;
            J      <= j_n;
            ready  <= ready_n;
            busy   <= ~ready_n;
            done   <= done_n;
`ifdef PREAMBLE_EN
            pre_sh <= pre_sh_n;
`endif
        end
    end

endmodule

// File: tb/tb_s10000001_frame_tx.sv
// tb_s10000001_frame_tx
//   Directed and random stimulus for s10000001_frame_tx, checked cycle by cycle
//   against a frame-schedule model. Honours PREAMBLE_EN like the design.
module tb_s10000001_frame_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned GAP_W = 4;
    localparam logic [7:0]  SYNC_W = 8'b10000001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             J, ready, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ycnt     = 0;
    logic [7:0] hist = '0;

    typedef struct packed {
        logic j;
        logic done;
        logic ready;
    } exp_t;

    exp_t q[$];
    exp_t cur = '{j: 1'b0, done: 1'b0, ready: 1'b1};

    s10000001_frame_tx #(.WIDTH(WIDTH), .GAP_W(GAP_W), .SYNC(SYNC_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .gap   (gap),
        .J     (J),
        .ready (ready),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Whole-frame schedule: a start seen while idle queues every future cycle's
    // expected (J, done, ready); reset discards whatever is pending.
    task automatic model_edge();
        logic [7:0] d;
        if (rst) begin
            q.delete();
            cur = '{j: 1'b0, done: 1'b0, ready: 1'b1};
        end else begin
            if (cur.ready && start) begin
`ifdef PREAMBLE_EN
                d = SYNC_W;
                for (int i = 0; i < 8; i++) begin
                    q.push_back('{j: d[7], done: 1'b0, ready: 1'b0});
                    d = d << 1;
                end
`endif
                d = data;
                for (int i = 0; i < 8; i++) begin
                    q.push_back('{j: d[7], done: 1'b0, ready: 1'b0});
                    d = d << 1;
                end
                q.push_back('{j: 1'b0, done: 1'b1, ready: (gap == '0)});
                for (int k = 1; k < int'(gap); k++)
                    q.push_back('{j: 1'b0, done: 1'b0, ready: 1'b0});
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = '{j: 1'b0, done: 1'b0, ready: 1'b1};
        end
    endtask

    // One clock: advance the model on the pre-edge inputs, then sample #1 later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        hist = {hist[6:0], J};
        if (hist == 8'b10000001) ycnt++;
        chk1($sformatf("J@%0d", cyc),     J,     cur.j);
        chk1($sformatf("done@%0d", cyc),  done,  cur.done);
        chk1($sformatf("ready@%0d", cyc), ready, cur.ready);
        chk1($sformatf("busy@%0d", cyc),  busy,  ~cur.ready);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int y0;

        // Reset held two cycles, then idle with start low.
        rst = 1'b1; start = 1'b0;
        steps(2);
        rst = 1'b0;
        steps(5);

        // Single frame 0x81 with gap 3; later data changes must not matter.
        hist = '0;
        y0 = ycnt;
        data = 8'h81; gap = 4'd3; start = 1'b1;
        step();
        start = 1'b0; data = 8'h5A; gap = 4'd9;
        steps(20);
`ifdef PREAMBLE_EN
        chk32("y_pulses_81", ycnt - y0, 2);
`else
        chk32("y_pulses_81", ycnt - y0, 1);
`endif

        // Back-to-back with start held and gap 0.
        data = 8'hC1; gap = 4'd0; start = 1'b1;
        step();
        data = 8'h81;
        steps(25);
        start = 1'b0;
        steps(25);

        // Start pulsed at E+3 mid-frame with other data is ignored.
        data = 8'hA5; gap = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        steps(2);
        data = 8'h3C; start = 1'b1;
        step();
        start = 1'b0;
        steps(25);

        // Reset at E+4 abandons the frame with no done.
        data = 8'hFF; gap = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(20);

`ifdef PREAMBLE_EN
        // Preamble then an all-zero payload: detector fires once on SYNC.
        hist = '0;
        y0 = ycnt;
        data = 8'h00; gap = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        steps(20);
        chk32("y_pulses_pre", ycnt - y0, 1);
`endif

        // Random traffic: sporadic starts (also while busy), random gaps, rare resets.
        for (int n = 0; n < 1500; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            data  = WIDTH'($urandom);
            gap   = GAP_W'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0; start = 1'b0;
        steps(45);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s10000001_frame_tx.md
# s10000001_frame_tx

Serial frame transmitter that drives the single-bit line `J` consumed by the `10000001` sequence detector. It captures an 8-bit word on a start handshake and shifts it out MSB-first, one bit per clock. An optional idle gap can follow each frame. The block sits upstream of the detector and replaces hand-written bit stimulus with a registered, cycle-exact source.

## Interface
Parameters:
- `WIDTH`, 8: payload bits per frame.
- `GAP_W`, 4: width of the gap-length input.
- `SYNC`, 8'b10000001: preamble word. Used only with `PREAMBLE_EN`. Its width is `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request. Sampled only while `ready`=1.
- `data`  in  WIDTH  payload. Captured with `start`.
- `gap`  in  GAP_W  number of idle bits after the payload. Captured with `start`.
- `J`  out  1  registered serial line.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last payload bit.

## Operation
- States: IDLE, PRE (only with `PREAMBLE_EN`), SEND, GAP.
- Reset values: state=IDLE, `J`=0, `ready`=1, `busy`=0, `done`=0, shift register=0, counters=0.
- **IDLE**
  - `J`=0.
  - On `start`=1: latch `data` into the shift register and `gap` into the gap counter.
  - Next state is PRE if `PREAMBLE_EN` is defined, otherwise SEND.
- **PRE**
  - Emits `SYNC` MSB-first over exactly `WIDTH` cycles, then goes to SEND.
- **SEND**
  - Emits the latched payload MSB-first over exactly `WIDTH` cycles.
  - The bit counter counts from WIDTH-1 down to 0.
  - After the last bit: go to GAP if the latched gap is nonzero, otherwise go to IDLE. `done` pulses in that transition.
- **GAP**
  - `J`=0 for exactly the latched `gap` cycles, then go to IDLE.
- `start` outside IDLE is ignored and not queued.
- `data` and `gap` changes after capture have no effect on the frame in progress.
- `rst` takes priority over everything. Asserting it in any state returns every output to its reset value on the next edge; the frame is abandoned, not completed.

## Timing
- Let E be the edge where `start`=1 is sampled in IDLE.
- Without `PREAMBLE_EN`:
  - Payload bit WIDTH-1-i drives `J` from edge E+i to E+i+1, for i=0..WIDTH-1.
- With `PREAMBLE_EN`:
  - `SYNC` occupies edges E..E+WIDTH-1.
  - The payload is shifted by WIDTH cycles.
- Let L be the edge after the last payload bit (E+WIDTH, or E+2·WIDTH with the preamble). At L:
  - `J`=0 and `done`=1 for one cycle.
  - `busy` stays 1 if gap>0.
  - `ready` rises at L+gap.
- Minimum spacing: with gap=0 and `start` held high, the next frame's first bit appears at L+1. There is always at least one idle 0 between frames, coming from the IDLE cycle.
- `busy` = ~`ready` at all times. Both are registered and update on the same edges as the state.

## Configuration
- `PREAMBLE_EN` defined:
  - Every frame is `SYNC` followed by the payload, 2·WIDTH bits.
  - The downstream detector asserts `Y` on the final `SYNC` bit of each frame.
- `PREAMBLE_EN` undefined:
  - The PRE state and the `SYNC` logic are not compiled.
  - Frames are payload only, WIDTH bits.
  - `SYNC` is unused.

## Test plan
- Reset → `J`=0, `ready`=1, `busy`=0, `done`=0.
- Hold `rst`=1 for 2 cycles and `start`=0 for 5 cycles → `J` stays 0 throughout.
- No preamble, `data`=8'b10000001, gap=3, `start` for one cycle at E:
  - `J` = 1,0,0,0,0,0,0,1 on cycles E..E+7.
  - `done`=1 only at E+8.
  - `J`=0 on cycles E+8..E+10.
  - `ready`=1 at E+11.
  - The detector `Y` pulses once.
- Back-to-back: gap=0, `start` held high, `data`=8'hC1 then 8'h81 → the second frame's MSB appears at E+9, after exactly one idle 0.
- `start` pulsed at E+3 during SEND with a different `data` → ignored: the frame and the `done` timing are unchanged, and no second frame follows.
- `rst` asserted at E+4 mid-frame → `J`=0, `busy`=0, `done`=0 on the next edge. No `done` ever pulses for the aborted frame.
- With `PREAMBLE_EN`, `data`=8'h00, gap=0:
  - `J` = 1,0,0,0,0,0,0,1 then eight 0s.
  - The detector `Y` pulses at E+7.
  - `done` pulses at E+16.
